// File: rtl/onchip_mem_ctrl.sv
// onchip_mem_ctrl: Avalon-MM single-port RAM slave with hardware clear engine and pipelined reads
module onchip_mem_ctrl #(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 14,
  parameter int                DEPTH        = 16384,
  parameter int                READ_LATENCY = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  input  logic                clear_req,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                busy
);
  localparam int NB = DATA_W / 8;
  typedef enum logic {S_CLEAR, S_READY} state_t;
  state_t                  r_state, w_state_nxt;
  logic [ADDR_W-1:0]       r_clr_addr, w_clr_nxt;
  logic [DATA_W-1:0]       r_mem [DEPTH];
  logic [DATA_W-1:0]       r_pd [READ_LATENCY];
  logic [READ_LATENCY-1:0] r_pv;
  logic                    w_acc, w_wr_acc, w_rd_acc, w_in_range, w_clr_last;
  logic [DATA_W-1:0]       w_rd_word;

  assign waitrequest   = (r_state != S_READY) | ~clken;
  assign busy          = r_state == S_CLEAR;
  assign w_acc         = chipselect & ~waitrequest & (read | write);
  assign w_wr_acc      = w_acc & write;
  assign w_rd_acc      = w_acc & read & ~write;
  assign w_in_range    = {1'b0, address} < (ADDR_W + 1)'(DEPTH);
  assign w_clr_last    = r_clr_addr == ADDR_W'(DEPTH - 1);
  assign w_rd_word     = w_in_range ? r_mem[address] : '0;
  assign readdata      = r_pd[READ_LATENCY-1];
  assign readdatavalid = r_pv[READ_LATENCY-1];

  // state and clear counter, frozen while clken is low
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
    end else if (clken) begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_nxt;
    end

  // clear sweeps the array once then opens the bus; clear_req from READY restarts the sweep
  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = '0;
    if (r_state == S_CLEAR) begin
      w_clr_nxt = w_clr_last ? '0 : r_clr_addr + ADDR_W'(1);
      if (w_clr_last) w_state_nxt = S_READY;
    end else if (clear_req) begin
      w_state_nxt = S_CLEAR;
    end
  end

  // array port: the clear engine owns it while busy, accepted bus writes otherwise
  always_ff @(posedge clk)
    if (clken && busy)
      r_mem[r_clr_addr] <= INIT_VALUE;
    else if (w_wr_acc && w_in_range)
      for (int i = 0; i < NB; i++)
        if (byteenable[i]) r_mem[address][i*8 +: 8] <= writedata[i*8 +: 8];

  // read pipeline: data is captured at acceptance and a stage only loads on a valid word so readdata holds
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_pv <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_pd[i] <= '0;
    end else if (clken) begin
      r_pv[0] <= w_rd_acc;
      if (w_rd_acc) r_pd[0] <= w_rd_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) r_pd[i] <= r_pd[i-1];
      end
    end
endmodule

// File: tb/tb_onchip_mem_ctrl.sv
// tb_onchip_mem_ctrl: two configurations driven together, checked every cycle against a queue-based model
module tb_onchip_mem_ctrl;
  logic        clk = 1'b0, reset_n = 1'b1;
  logic [3:0]  address = '0, byteenable = '0;
  logic        chipselect = 1'b0, read = 1'b0, write = 1'b0, clken = 1'b1, clear_req = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] rd0, rd1;
  logic        rdv0, rdv1, wr0, wr1, bz0, bz1;
  int          total = 0, bad = 0;
  logic [31:0] m_mem [2][16];
  int          m_left [2];
  logic [31:0] m_rd [2];
  logic        m_rdv [2];
  logic [31:0] p_d [2][4];
  int          p_r [2][4];
  int          p_n [2];

  always #5 clk = ~clk;

  onchip_mem_ctrl #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .READ_LATENCY(1), .INIT_VALUE(32'hA5A5A5A5)) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .clken(clken), .clear_req(clear_req),
    .readdata(rd0), .readdatavalid(rdv0), .waitrequest(wr0), .busy(bz0));

  onchip_mem_ctrl #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .READ_LATENCY(2), .INIT_VALUE(32'h0)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .clken(clken), .clear_req(clear_req),
    .readdata(rd1), .readdatavalid(rdv1), .waitrequest(wr1), .busy(bz1));

  function automatic int dep(int k);
    return k == 0 ? 12 : 16;
  endfunction

  function automatic logic [31:0] init_val(int k);
    return k == 0 ? 32'hA5A5A5A5 : 32'h0;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = dep(k);
      m_rd[k]   = '0;
      m_rdv[k]  = 1'b0;
      p_n[k]    = 0;
    end
  endtask

  // one enabled clock edge of instance k: clear step or bus op, then reads age by one cycle
  task automatic model_edge(int k);
    if (m_left[k] > 0) begin
      m_mem[k][dep(k) - m_left[k]] = init_val(k);
      m_left[k]--;
    end else begin
      if (chipselect && write) begin
        if (int'(address) < dep(k))
          for (int i = 0; i < 4; i++)
            if (byteenable[i]) m_mem[k][address][i*8 +: 8] = writedata[i*8 +: 8];
      end else if (chipselect && read) begin
        p_d[k][p_n[k]] = int'(address) < dep(k) ? m_mem[k][address] : 32'h0;
        p_r[k][p_n[k]] = k + 1;
        p_n[k]++;
      end
      if (clear_req) m_left[k] = dep(k);
    end
    for (int i = 0; i < p_n[k]; i++) p_r[k][i]--;
    m_rdv[k] = 1'b0;
    if (p_n[k] > 0 && p_r[k][0] == 0) begin
      m_rdv[k] = 1'b1;
      m_rd[k]  = p_d[k][0];
      for (int i = 1; i < p_n[k]; i++) begin
        p_d[k][i-1] = p_d[k][i];
        p_r[k][i-1] = p_r[k][i];
      end
      p_n[k]--;
    end
  endtask

  // called at a falling edge with inputs set: compare all outputs, advance the model, run one clock
  task automatic tick();
    #1;
    if (!reset_n) model_reset();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("waitrequest%0d", k), 32'(k != 0 ? wr1 : wr0), 32'(m_left[k] > 0 || !clken));
      check($sformatf("busy%0d", k), 32'(k != 0 ? bz1 : bz0), 32'(m_left[k] > 0));
      check($sformatf("readdatavalid%0d", k), 32'(k != 0 ? rdv1 : rdv0), 32'(m_rdv[k]));
      check($sformatf("readdata%0d", k), k != 0 ? rd1 : rd0, m_rd[k]);
    end
    if (reset_n && clken) for (int k = 0; k < 2; k++) model_edge(k);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic op(logic c, logic r, logic w, logic [3:0] a, logic [3:0] be, logic [31:0] wd);
    chipselect = c;
    read       = r;
    write      = w;
    address    = a;
    byteenable = be;
    writedata  = wd;
    tick();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  // counts cycles with waitrequest (or busy) high over a fixed idle window
  task automatic count_high(input logic use_busy, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 20; i++) begin
      if (use_busy ? bz0 : wr0) c0++;
      if (use_busy ? bz1 : wr1) c1++;
      idle(1);
    end
  endtask

  initial begin
    int c0, c1;
    for (int k = 0; k < 2; k++) for (int a = 0; a < 16; a++) m_mem[k][a] = '0;
    model_reset();
    #1 reset_n = 1'b0;
    @(negedge clk);
    idle(2);
    reset_n = 1'b1;
    count_high(1'b0, c0, c1);
    check("clear_len_a", c0, 12);
    check("clear_len_b", c1, 16);
    for (int a = 0; a < 16; a++) op(1'b1, 1'b1, 1'b0, 4'(a), 4'h0, 32'h0);
    idle(3);
    op(1'b1, 1'b0, 1'b1, 4'd3, 4'b0101, 32'h11223344);
    op(1'b1, 1'b1, 1'b0, 4'd3, 4'h0, 32'h0);
    idle(3);
    check("lanes_a", rd0, 32'hA522A544);
    check("lanes_b", rd1, 32'h00220044);
    op(1'b1, 1'b0, 1'b1, 4'd1, 4'hF, 32'd10);
    op(1'b1, 1'b0, 1'b1, 4'd2, 4'hF, 32'd20);
    op(1'b1, 1'b0, 1'b1, 4'd3, 4'hF, 32'd30);
    for (int a = 1; a <= 3; a++) op(1'b1, 1'b1, 1'b0, 4'(a), 4'h0, 32'h0);
    idle(3);
    check("burst_last_b", rd1, 32'd30);
    op(1'b1, 1'b0, 1'b1, 4'd5, 4'hF, 32'hDEAD);
    op(1'b1, 1'b1, 1'b0, 4'd2, 4'h0, 32'h0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    count_high(1'b1, c0, c1);
    check("busy_len_a", c0, 12);
    check("busy_len_b", c1, 16);
    op(1'b1, 1'b1, 1'b0, 4'd5, 4'h0, 32'h0);
    idle(3);
    check("recleared_a", rd0, 32'hA5A5A5A5);
    check("recleared_b", rd1, 32'h0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    idle(5);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    count_high(1'b0, c0, c1);
    check("restart_len_a", c0, 12);
    check("restart_len_b", c1, 16);
    op(1'b1, 1'b0, 1'b1, 4'd14, 4'hF, 32'hCAFEF00D);
    op(1'b1, 1'b1, 1'b0, 4'd14, 4'h0, 32'h0);
    idle(3);
    check("out_of_range_a", rd0, 32'h0);
    check("in_range_b", rd1, 32'hCAFEF00D);
    op(1'b1, 1'b1, 1'b1, 4'd7, 4'hF, 32'h77777777);
    idle(3);
    op(1'b1, 1'b1, 1'b0, 4'd7, 4'h0, 32'h0);
    clken = 1'b0;
    idle(3);
    clken = 1'b1;
    idle(3);
    check("rw_write_lands_b", rd1, 32'h77777777);
    for (int i = 0; i < 800; i++) begin
      chipselect = $urandom_range(0, 3) != 0;
      read       = $urandom_range(0, 1) != 0;
      write      = $urandom_range(0, 2) == 0;
      address    = 4'($urandom_range(0, 15));
      byteenable = 4'($urandom);
      writedata  = $urandom;
      clken      = $urandom_range(0, 7) != 0;
      clear_req  = $urandom_range(0, 80) == 0;
      reset_n    = $urandom_range(0, 400) != 0;
      tick();
    end
    reset_n = 1'b1;
    clken   = 1'b1;
    clear_req = 1'b0;
    idle(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/onchip_mem_ctrl.md
# onchip_mem_ctrl

Parametrised Avalon-MM single-port on-chip RAM slave with a hardware clear engine, pipelined reads and flow control. It replaces the fixed 32x16384 on-chip memory in the Qsys system. Width, depth and read latency are configurable, and `readdatavalid`/`waitrequest` are added. After every reset, or on request, it fills the array with a programmable value before accepting traffic.

## Interface
- `DATA_W`, 32: data width in bits; multiple of 8.
- `ADDR_W`, 14: word address width.
- `DEPTH`, 16384: number of words; 2 ≤ `DEPTH` ≤ 2^`ADDR_W`.
- `READ_LATENCY`, 1: cycles from read acceptance to `readdatavalid`; legal values are 1 or 2.
- `INIT_VALUE`, 0: word written to every location by the clear engine.

Ports (clock and reset first):
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  `ADDR_W`  word address.
- `byteenable`  in  `DATA_W`/8  write byte lanes.
- `chipselect`  in  1  slave select.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `writedata`  in  `DATA_W`  write data.
- `clken`  in  1  clock enable; low freezes all state except reset.
- `clear_req`  in  1  single-cycle pulse that requests a re-clear.
- `readdata`  out  `DATA_W`  read data, qualified by `readdatavalid`.
- `readdatavalid`  out  1  read data valid strobe.
- `waitrequest`  out  1  high means the request is not accepted.
- `busy`  out  1  high while the clear engine runs.

## Operation
- State machine, registered:
  - **CLEAR**: counter `clr_addr` runs 0..`DEPTH`-1. Each cycle with `clken`=1 writes `INIT_VALUE` to mem[`clr_addr`] with all byte lanes enabled. At `clr_addr`=`DEPTH`-1 the FSM moves to READY.
  - **READY**: serves bus traffic. `clear_req`=1 resets `clr_addr` to 0 and moves to CLEAR.
- Reset: FSM=CLEAR, `clr_addr`=0, `readdata`=0, `readdatavalid`=0, `waitrequest`=1, `busy`=1. Reset during CLEAR restarts the clear from address 0. Reset also flushes any in-flight reads, with no `readdatavalid`.
- `waitrequest` = (FSM≠READY) | ~`clken`. `busy` = (FSM=CLEAR).
- Accept = `chipselect` & ~`waitrequest` & (`read` | `write`).
- Write accept: for each lane i with `byteenable`[i]=1, mem[`address`] byte i takes `writedata` byte i. Lanes with `byteenable`=0 are unchanged.
- Read accept: `address` enters the read pipeline. The stage count equals `READ_LATENCY`. The last stage drives `readdata`/`readdatavalid`.
- `read` and `write` asserted together: the write is performed, the read is dropped, and no `readdatavalid` is issued.
- Out-of-range address (`address` ≥ `DEPTH`): the write is dropped. The read is accepted normally and returns all-zero data with `readdatavalid` asserted.
- `readdata` holds its last value when `readdatavalid`=0.
- `clear_req` in CLEAR is ignored. `clear_req` while reads are in flight lets those reads complete with pre-clear data.
- `clken`=0: no writes, the clear counter and read pipeline hold, and `readdatavalid` is held at its current value for the frozen cycle(s).

## Timing
- Reads:
  - Read accepted at edge N gives `readdatavalid`=1 after edge N+`READ_LATENCY`, for exactly one cycle.
  - Back-to-back reads sustain 1 word/cycle.
- Writes:
  - Write at edge N is visible to a read accepted at edge N+1.
  - There is no same-cycle read/write bypass; none is needed because the port is single.
- Clear:
  - CLEAR lasts `DEPTH` enabled cycles.
  - `waitrequest` falls one cycle after the final clear write. With `DEPTH`=16384 and `clken`=1, that is 16384 cycles after `reset_n` rises.
- `clear_req` sampled at edge N: `waitrequest`=1 from edge N onward, and the array is fully cleared `DEPTH` enabled cycles later.
- All outputs are registered, except `waitrequest`, which is combinational from the FSM register and `clken`.

## Test plan
- **Reset and clear:** release `reset_n`, DEPTH=16, INIT_VALUE=32'hA5A5A5A5 → `waitrequest` stays high for exactly 16 cycles. Then read addresses 0..15: each returns A5A5A5A5, with `readdatavalid` 1 cycle after acceptance (LAT=1).
- **Byte-lane writes:** write 32'h11223344 to addr 3 with `byteenable`=4'b0101, after a clear to 0 → read addr 3 returns 32'h00220044.
- **Pipelined reads:** READ_LATENCY=2, back-to-back reads of addr 1,2,3 holding 10,20,30 → `readdatavalid` high on 3 consecutive cycles starting 2 cycles after the first accept, with data 10,20,30.
- **Mid-operation events:**
  - `clear_req` pulse after writing addr 5=32'hDEAD → `busy` high for DEPTH cycles, then addr 5 reads INIT_VALUE.
  - `reset_n` low for 1 cycle mid-clear → the clear restarts and takes a full DEPTH cycles.
- **Corner cases:**
  - DEPTH=12, ADDR_W=4: write addr 14 is dropped; read addr 14 returns 0 with valid.
  - `read`+`write` together → the write lands and no `readdatavalid` is issued.
  - `clken`=0 for 3 cycles mid-read → `readdatavalid` is delayed by 3 cycles.
